// File: rtl/phy_rx_fifo.sv
// phy_rx_fifo: RX byte FIFO with pop handshake, occupancy flags and a sticky overflow flag
module phy_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d, overflow_q, overflow_d;
  logic              push_ok, pop_ok;
  always_comb begin
    full         = count_q == (ADDR_W+1)'(DEPTH);
    empty        = count_q == '0;
    almost_full  = count_q >= (ADDR_W+1)'(AFULL_TH);
    almost_empty = count_q <= (ADDR_W+1)'(AEMPTY_TH);
    pop_ok       = pop && !empty;
    push_ok      = valid_in && (!full || pop_ok);
    wr_ptr_d     = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q + {{ADDR_W{1'b0}}, push_ok} - {{ADDR_W{1'b0}}, pop_ok};
    data_out_d   = pop_ok ? mem_q[rd_ptr_q] : data_out_q;
    valid_out_d  = pop_ok;
    overflow_d   = overflow_q || (valid_in && full && !pop_ok);
  end
  always_ff @(posedge clk_f or negedge reset_L)
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  always_ff @(posedge clk_f)
    if (push_ok) mem_q[wr_ptr_q] <= data_in;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_phy_rx_fifo.sv
// tb_phy_rx_fifo: scoreboard bench for phy_rx_fifo with directed vectors
module tb_phy_rx_fifo;
  logic       clk_f = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty, overflow;
  logic [3:0] count;
  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  phy_rx_fifo dut (
    .clk_f(clk_f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count), .overflow(overflow)
  );
  always #5 clk_f = ~clk_f;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask
  task automatic chk_state();
    int n = model.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == 8));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= 6));
    chk("almost_empty", int'(almost_empty), int'(n <= 2));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic p);
    logic pok, wok;
    @(negedge clk_f);
    chk_state();
    valid_in = v;
    data_in  = d;
    pop      = p;
    pok = p && model.size() > 0;
    wok = v && (model.size() < 8 || pok);
    if (v && model.size() == 8 && !pok) m_ovf = 1'b1;
    if (pok) exp_q.push_back(model.pop_front());
    if (wok) model.push_back(d);
  endtask
  task automatic do_reset();
    @(negedge clk_f);
    valid_in = 1'b0;
    pop = 1'b0;
    reset_L = 1'b0;
    model.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    @(negedge clk_f);
    reset_L = 1'b1;
  endtask
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge clk_f);
      if (reset_L && valid_out) begin
        if (exp_q.size() == 0) chk("unexpected_valid_out", int'(data_out), -1);
        else begin
          got = exp_q.pop_front();
          chk("data_out", int'(data_out), int'(got));
        end
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk_f);
    reset_L = 1'b1;
    @(negedge clk_f);
    chk("t1_empty", int'(empty), 1);
    chk("t1_almost_empty", int'(almost_empty), 1);
    chk("t1_count", int'(count), 0);
    chk("t1_valid_out", int'(valid_out), 0);
    chk("t1_data_out", int'(data_out), 8'h00);
    chk("t1_overflow", int'(overflow), 0);
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(0, 8'h00, 0);
    chk("t2_count", int'(count), 3);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    chk("t2_empty", int'(empty), 1);
    step(0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 8'hA0 + 8'(i), 0);
      chk("t3_almost_full", int'(almost_full), int'(i >= 6));
    end
    step(1, 8'hFF, 0);
    chk("t3_full", int'(full), 1);
    step(0, 8'h00, 0);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_count", int'(count), 8);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("t3_overflow_sticky", int'(overflow), 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 8'h40 + 8'(i), 0);
    step(1, 8'h55, 1);
    step(0, 8'h00, 0);
    chk("t4_count", int'(count), 8);
    chk("t4_overflow", int'(overflow), 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("t4_empty", int'(empty), 1);
    step(1, 8'h77, 1);
    step(0, 8'h00, 0);
    chk("t5_valid_out", int'(valid_out), 0);
    chk("t5_count", int'(count), 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    for (int i = 0; i < 20; i++) step(1, 8'hC0 + 8'(i), 1'(i % 3 != 0));
    while (model.size() > 5) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("t6_count_before_reset", int'(count), 5);
    @(posedge clk_f);
    #2;
    reset_L = 1'b0;
    model.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    #1;
    chk("t6_async_count", int'(count), 0);
    chk("t6_async_empty", int'(empty), 1);
    chk("t6_async_almost_empty", int'(almost_empty), 1);
    chk("t6_async_full", int'(full), 0);
    chk("t6_async_valid_out", int'(valid_out), 0);
    chk("t6_async_data_out", int'(data_out), 8'h00);
    @(negedge clk_f);
    reset_L = 1'b1;
    step(1, 8'hBC, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("missing_valid_out", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/phy_rx_fifo.md
Name: phy_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the PHY RX serial-to-parallel stage.
- Accepts the 8-bit aligned byte stream (data_in/valid_in) produced at clk_f.
- Stores the bytes in a circular FIFO.
- Presents them to the consumer through a pop handshake.
- Reports occupancy, almost-full/almost-empty flags and a sticky overflow error so upper layers can apply flow control.

Parameters:
- DATA_W, 8, byte width of stored words.
- DEPTH, 8, number of entries; must be a power of 2, minimum 4.
- ADDR_W, 3, log2(DEPTH).
- AFULL_TH, 6, almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserted when count <= AEMPTY_TH.

Ports:
- clk_f  input  1  byte clock shared with the RX serial-to-parallel output stage
- reset_L  input  1  asynchronous, active-low reset
- data_in  input  DATA_W  parallel byte from serial-to-parallel stage
- valid_in  input  1  data_in carries a valid (non-idle) byte this cycle
- pop  input  1  consumer requests one byte
- data_out  output  DATA_W  popped byte, registered
- valid_out  output  1  data_out valid, one-cycle pulse per successful pop
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_TH
- almost_empty  output  1  count <= AEMPTY_TH
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was dropped while full

Behaviour:
- Reset (reset_L low, asynchronous, effective immediately):
  - Pointers and count are 0.
  - data_out is 0, valid_out is 0, full is 0, empty is 1, almost_full is 0, almost_empty is 1, overflow is 0.
  - Memory contents are don't-care.
- Reset deasserted mid-stream: all in-flight data is discarded; the first push after release lands in entry 0.
- All state updates on the rising edge of clk_f.
- Push:
  - push_ok = valid_in && (!full || pop_ok).
  - On push_ok, mem[wr_ptr] <= data_in and wr_ptr increments, wrapping modulo DEPTH.
- Pop:
  - pop_ok = pop && !empty.
  - On pop_ok, data_out <= mem[rd_ptr], rd_ptr increments with wrap, and valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its last value.
  - Latency: the byte appears on data_out/valid_out the cycle after pop is sampled.
- Simultaneous push and pop:
  - Full: both succeed; count is unchanged, no overflow.
  - Empty: pop is ignored (no fall-through bypass); push succeeds; count becomes 1; valid_out stays 0.
  - Otherwise: both succeed; count is unchanged.
- Count update: count <= count + push_ok - pop_ok. It never exceeds DEPTH and never underflows.
- Overflow: valid_in && full && !pop_ok sets overflow to 1. The byte is dropped and pointers are unchanged. overflow clears only on reset.
- Pop on empty: no state change, valid_out 0, no error flag.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count. They are glitch-free with respect to clk_f and update in the same cycle count changes.
- Ordering: strict FIFO order; byte values including 8'hBC pass through unmodified (idle filtering is done upstream via valid_in).

Test Plan:
1. Reset with pop and valid_in low: after reset_L is released, check empty=1, almost_empty=1, count=0, valid_out=0, data_out=8'h00, overflow=0.
2. Push 8'h11, 8'h22, 8'h33 on consecutive cycles, then pop three times. Required response:
   - count=3 before the pops.
   - data_out is 8'h11, 8'h22, 8'h33 with valid_out high, each one cycle after its pop.
   - Then empty=1.
3. Push 8 bytes 8'hA0..8'hA7:
   - almost_full rises when count reaches 6.
   - full=1 at count=8.
   - A ninth push of 8'hFF sets overflow=1 and count stays 8.
   - Draining all 8 entries yields 8'hA0..8'hA7 in order; 8'hFF is absent and overflow remains 1.
4. With the FIFO full, assert push of 8'h55 and pop together. Required response: count stays 8, overflow stays 0, data_out equals the oldest entry, and 8'h55 is later popped last.
5. With the FIFO empty, assert push of 8'h77 and pop together. Required response: valid_out=0, count=1; the next pop returns 8'h77.
6. Wrap and async reset:
   - Stream 20 bytes with interleaved pops so the pointers wrap at least twice; verify order and count every cycle against a reference queue.
   - Assert reset_L low between clock edges with count=5. Required response: outputs return to reset values immediately, without waiting for a clk_f edge.
